// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with occupancy count, almost flags and optional sticky errors (SYNC_FIFO_ERR_EN).
// Latency: a word written at edge N is visible on read_data right after edge N; reads pop with zero latency.
// Backpressure: writes are dropped while full and reads ignored while empty; no state changes on a rejected request.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_en,
    input  logic [DATA_W-1:0]          write_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       read_en,
    output logic [DATA_W-1:0]          read_data,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t AF_THR  = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_THR  = ptr_t'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // MSB of each pointer is the wrap phase; equal indices with differing phase means full.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= write_data;
        end
    end

    assign read_data    = mem[rd_ptr[AW-1:0]];
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 2;
`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              write_en = 1'b0;
    logic [DATA_W-1:0] write_data = '0;
    logic              read_en = 1'b0;
    logic              full;
    logic              almost_full;
    logic [DATA_W-1:0] read_data;
    logic              empty;
    logic              almost_empty;
    logic [3:0]        count;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] model_q [$];
    bit                model_ovf = 1'b0;
    bit                model_unf = 1'b0;

    sync_fifo_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_en    (write_en),
        .write_data  (write_data),
        .full        (full),
        .almost_full (almost_full),
        .read_en     (read_en),
        .read_data   (read_data),
        .empty       (empty),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = model_q.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("full", 32'(full), 32'(n == DEPTH));
        check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
        if (n > 0) begin
            check_eq("read_data", 32'(read_data), 32'(model_q[0]));
        end
        check_eq("overflow", 32'(overflow), 32'(ERR_EN && model_ovf));
        check_eq("underflow", 32'(underflow), 32'(ERR_EN && model_unf));
    endtask

    // One clock of stimulus; the model decides acceptance from the occupancy before the edge.
    task automatic step(input bit we, input logic [DATA_W-1:0] wd, input bit re);
        int  n;
        bit  wr_ok;
        bit  rd_ok;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        @(posedge clk);
        n = model_q.size();
        if (we && n == DEPTH) model_ovf = 1'b1;
        if (re && n == 0)     model_unf = 1'b1;
        rd_ok = re && (n > 0);
        wr_ok = we && (n < DEPTH);
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(wd);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset(input bit we, input bit re);
        reset    = 1'b1;
        write_en = we;
        read_en  = re;
        write_data = 8'hFF;
        @(posedge clk);
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        #1;
        reset    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_outputs();
    endtask

    initial begin
        // Reset and idle
        do_reset(1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);

        // Fill past full, then drain past empty
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0);
        check_eq("ninth_write_dropped_count", 32'(count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            check_eq("drain_order", 32'(read_data), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h55, 1'b0);
        check_eq("sticky_underflow", 32'(underflow), 32'(ERR_EN));
        do_reset(1'b0, 1'b0);

        // Wrap across phase toggles
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h10 + r * 5 + k), 1'b0);
            for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1);
        end
        check_eq("wrap_end_count", 32'(count), 32'd0);

        // Simultaneous read/write at empty, full and mid occupancy
        step(1'b1, 8'hA5, 1'b1);
        check_eq("simul_empty_head", 32'(read_data), 32'hA5);
        for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h20 + k), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        check_eq("simul_full_count", 32'(count), 32'd7);
        check_eq("simul_full_head", 32'(read_data), 32'h20);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        check_eq("simul_mid_count", 32'(count), 32'd3);

        // Reset mid-operation, with requests held active during reset
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h40 + k), 1'b0);
        do_reset(1'b1, 1'b1);
        check_eq("reset_mid_count", 32'(count), 32'd0);
        step(1'b1, 8'h3C, 1'b0);
        check_eq("post_reset_data", 32'(read_data), 32'h3C);

        // Overflow is sticky until reset
        for (int k = 0; k < 8; k++) step(1'b1, 8'(k), 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        check_eq("sticky_overflow", 32'(overflow), 32'(ERR_EN));
        do_reset(1'b0, 1'b0);

        // Random traffic with phases biased toward filling and draining
        for (int i = 0; i < 1200; i++) begin
            int  wp;
            bit  we;
            bit  re;
            case ((i / 100) % 3)
                0:       wp = 80;
                1:       wp = 20;
                default: wp = 50;
            endcase
            if ($urandom_range(0, 149) == 0) begin
                do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end else begin
                we = ($urandom_range(0, 99) < wp);
                re = ($urandom_range(0, 99) < (100 - wp));
                step(we, 8'($urandom), re);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
